q_to_float_converter: RTL
=========================

# q_to_float_converter

Streaming decoder from signed fixed-point Q(M_IN.N_IN) (sign + M_IN integer + N_IN fractional bits, two's complement) to IEEE-754 binary32. It sits downstream of the Q-format datapath and hands fixed-point results to float consumers (soft-CPU, host DMA). It uses AXI-Stream on both sides. An iterative normaliser shifts one bit per cycle, so latency depends on the data; one sample is in flight at a time.

## Interface
- M_IN, default 1, integer bits (≥0)
- N_IN, default 1, fractional bits (≥0, ≤126)
- Constraint: W = M_IN+N_IN+1 must satisfy 2 ≤ W ≤ 32. Any other value is a generate-time error.
- aclk  in  1  clock; single clock domain, all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- s_axis_tdata  in  ((W+7)/8)*8  Q sample in bits [W-1:0]; upper pad bits ignored
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  packet boundary, carried with the sample
- m_axis_tdata  out  32  binary32 result
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  tlast of the accepted sample

## Operation
- FSM states:
  - IDLE: s_axis_tready = 1.
  - NORM: normalising.
  - OUT: m_axis_tvalid = 1.
- IDLE, on input handshake: capture sign = tdata[W-1] and tlast.
  - Capture mag = |x| as a W-bit unsigned value. The most negative input gives mag = 2^(W-1), which fits.
  - Load position counter p = W-1.
  - If mag == 0: result = 0x00000000 (+0.0), go to OUT.
  - Otherwise go to NORM.
- NORM, each cycle:
  - If mag[W-1] == 1: build the result and go to OUT.
  - Otherwise: shift mag left by 1 and decrement p.
- Result fields:
  - Sign bit = sign.
  - Biased exponent = p − N_IN + 127. Always in range 1..158, so denormals, Inf and NaN are never produced.
  - Mantissa = mag[W-2:0], MSB-aligned into 23 bits.
    - W-1 ≤ 23: zero-pad on the right; the result is exact.
    - W-1 > 23: keep the top 23 bits. Lower bits are handled per Configuration.
- OUT: hold tdata, tvalid and tlast stable until m_axis_tready = 1. On the handshake, go to IDLE.
- s_axis_tready = (state == IDLE) && !areset. It is registered-state derived; there is no combinational path from m_axis_tready.

## Timing
- Call the accepting edge E0, and let lz = leading zeros of mag in W bits.
- Nonzero input: m_axis_tvalid rises on edge E0+lz+1.
- Zero input: m_axis_tvalid rises on edge E0.
- Best-case throughput: one sample per lz+3 cycles. The next accept is possible on the cycle after the output handshake.
- Reset values:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - s_axis_tready = 0 while areset = 1.
  - State = IDLE.
- Reset in the middle of an operation, in NORM or OUT: the in-flight sample is discarded with no output. Ready returns on the first cycle after areset deasserts.
- Output backpressure stalls indefinitely with stable data. No input is accepted until the output drains.

## Configuration
- Q2F_ROUND_EN defined: round to nearest, ties to even, when W-1 > 23.
  - Guard bit = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment the mantissa if guard && (sticky || lsb).
  - A mantissa carry-out clears the mantissa and increments the exponent. This costs one extra NORM cycle, so latency becomes lz+2.
- Q2F_ROUND_EN undefined: truncate the magnitude toward zero, with no added latency.
- With W-1 ≤ 23 the two modes behave identically.

## Test plan
- M_IN=7, N_IN=8. Input 0x0100 (1.0) → 0x3F800000, tvalid on E0+8, tlast propagated. Input 0xFF80 (−0.5) → 0xBF000000.
- M_IN=7, N_IN=8. Input 0x8000 (−128.0) → 0xC3000000 on E0+1. Input 0x0000 → 0x00000000 on E0.
- M_IN=31, N_IN=0. Input 0x7FFFFFFF:
  - With Q2F_ROUND_EN → 0x4F000000.
  - Without → 0x4EFFFFFF.
- M_IN=31, N_IN=0. Input 0x01000003:
  - With Q2F_ROUND_EN → 0x4B800002.
  - Without → 0x4B800001.
  - Input 0x01000001 → 0x4B800000 in both modes.
- Backpressure: hold m_axis_tready = 0 for 10 cycles in OUT. Data, tvalid and tlast stay stable, s_axis_tready stays 0, and exactly one beat transfers on release.
- Assert areset for 1 cycle during NORM. There is no output beat, all outputs read their reset values, and the next sample converts correctly.

Source files
------------

// File: rtl/q_to_float_converter.sv
// q_to_float_converter
// Streaming converter from signed fixed-point Q(M_IN.N_IN) to IEEE-754 binary32.
// A serial normaliser shifts the magnitude left one bit per cycle until its MSB
// is set, so latency depends on the data. One sample is in flight at a time.
//
// Parameters:
//   M_IN  integer bits (>= 0)
//   N_IN  fractional bits (0..126)
//   W = M_IN + N_IN + 1 must lie in 2..32
//
// Optional feature macro: Q2F_ROUND_EN
//   defined   : round to nearest, ties to even, when W-1 > 23 (a mantissa
//               carry-out costs one extra normalise cycle)
//   undefined : truncate the magnitude toward zero
//
// Ports:
//   aclk           clock, rising edge
//   areset         synchronous active-high reset
//   s_axis_tdata   Q sample in bits [W-1:0], upper pad bits ignored
//   s_axis_tvalid  input valid
//   s_axis_tready  input ready (IDLE and not in reset)
//   s_axis_tlast   packet boundary carried with the sample
//   m_axis_tdata   binary32 result
//   m_axis_tvalid  output valid
//   m_axis_tready  output ready
//   m_axis_tlast   tlast of the accepted sample
module q_to_float_converter #(
  parameter int unsigned M_IN = 1,
  parameter int unsigned N_IN = 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [((M_IN+N_IN+1+7)/8)*8-1:0]  s_axis_tdata,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [31:0]                       m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int unsigned W        = M_IN + N_IN + 1;
  localparam int unsigned FW       = W - 1;
  localparam int unsigned PW       = 6;
  localparam int unsigned BIAS_ADJ = 127 - N_IN;

  if (W < 2 || W > 32 || N_IN > 126) begin : g_param_check
    $error("q_to_float_converter: W = M_IN+N_IN+1 must be 2..32 and N_IN <= 126");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t        state;
  logic          sign_q;
  logic          last_q;
  logic [W-1:0]  mag_q;
  logic [PW-1:0] pos_q;

  // Input sign and magnitude; the most negative value maps to 2^(W-1)
  logic         in_sign_c;
  logic [W-1:0] in_mag_c;
  assign in_sign_c = s_axis_tdata[W-1];
  assign in_mag_c  = in_sign_c ? W'(~s_axis_tdata[W-1:0] + W'(1)) : s_axis_tdata[W-1:0];

  // Fraction bits below the leading one, MSB-aligned; 24 zero bits below keep
  // guard/sticky at zero whenever the fraction fits in 23 bits
  logic [FW+23:0] ext_c;
  logic [22:0]    mant_c;
  logic           guard_c;
  logic           sticky_c;
  logic           round_up_c;
  logic [23:0]    mant_sum_c;
  logic           carry_c;
  logic [7:0]     exp_c;

  assign ext_c    = {mag_q[W-2:0], 24'b0};
  assign mant_c   = ext_c[FW+23 -: 23];
  assign guard_c  = ext_c[FW];
  assign sticky_c = |ext_c[FW-1:0];

`ifdef Q2F_ROUND_EN
  assign round_up_c = guard_c && (sticky_c || mant_c[0]);
`else
  assign round_up_c = 1'b0;
`endif

  assign mant_sum_c = {1'b0, mant_c} + 24'(round_up_c);
  assign carry_c    = mant_sum_c[23];
  assign exp_c      = 8'(32'(pos_q) + BIAS_ADJ);

  // Pad bits of the input and rounding taps that the truncating build ignores
  logic unused_c;
  assign unused_c = ^{s_axis_tdata, guard_c, sticky_c};

  assign s_axis_tready = (state == IDLE) && !areset;

  // Control, normaliser and registered output stage
  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      sign_q        <= 1'b0;
      last_q        <= 1'b0;
      mag_q         <= '0;
      pos_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axis_tvalid) begin
            sign_q <= in_sign_c;
            last_q <= s_axis_tlast;
            mag_q  <= in_mag_c;
            pos_q  <= PW'(W - 1);
            if (in_mag_c == '0) begin
              m_axis_tdata  <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= s_axis_tlast;
              state         <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mag_q[W-1]) begin
            if (carry_c) begin
              // Rounding overflowed the mantissa: renormalise to 1.0 x 2^(p+1)
              mag_q <= {1'b1, {(W-1){1'b0}}};
              pos_q <= pos_q + PW'(1);
            end else begin
              m_axis_tdata  <= {sign_q, exp_c, mant_sum_c[22:0]};
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= last_q;
              state         <= OUT;
            end
          end else begin
            mag_q <= mag_q << 1;
            pos_q <= pos_q - PW'(1);
          end
        end

        OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
